// File: rtl/msk_g4mul_arbiter.sv
// Round-robin arbiter that time-shares one masked GF(4) DOM multiplier between
// N requesters, pulling fresh randomness per issue and tagging results by owner.

module msk_g4mul_dom #(
  parameter int d = 2
) (
  input  logic                 clk,
  input  logic [d-1:0]         a0,
  input  logic [d-1:0]         a1,
  input  logic [d-1:0]         b0,
  input  logic [d-1:0]         b1,
  input  logic [d*(d-1)-1:0]   rnd,
  output logic [d-1:0]         out0,
  output logic [d-1:0]         out1
);

  // GF(4) in polynomial basis modulo x^2 + x + 1, element = {bit1, bit0}.
  function automatic logic [1:0] gf4_mul(input logic [1:0] x, input logic [1:0] y);
    return {(x[1] & y[1]) ^ (x[1] & y[0]) ^ (x[0] & y[1]),
            (x[0] & y[0]) ^ (x[1] & y[1])};
  endfunction

  // Index of the 2-bit random element shared by the cross terms (i,j) and (j,i), i<j.
  function automatic int pair_idx(input int i, input int j);
    return i * d - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

  logic [d-1:0][d-1:0][1:0] term_d;
  logic [d-1:0][d-1:0][1:0] term_q;
  logic [1:0]               prod;

  always_comb begin
    term_d = '0;
    prod   = '0;
    for (int i = 0; i < d; i++) begin
      for (int j = 0; j < d; j++) begin
        prod = gf4_mul({a1[i], a0[i]}, {b1[j], b0[j]});
        if (i < j)
          prod = prod ^ rnd[2*pair_idx(i, j) +: 2];
        else if (i > j)
          prod = prod ^ rnd[2*pair_idx(j, i) +: 2];
        term_d[i][j] = prod;
      end
    end
  end

  // Every partial product is registered before compression so no glitch can
  // combine shares of different domains.
  always_ff @(posedge clk) begin
    term_q <= term_d;
  end

  always_comb begin
    out0 = '0;
    out1 = '0;
    for (int i = 0; i < d; i++) begin
      for (int j = 0; j < d; j++) begin
        out0[i] = out0[i] ^ term_q[i][j][0];
        out1[i] = out1[i] ^ term_q[i][j][1];
      end
    end
  end

endmodule

module msk_g4mul_arbiter #(
  parameter int d = 2,
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_valid,
  output logic [N-1:0]         req_ready,
  input  logic [N*d-1:0]       req_a0,
  input  logic [N*d-1:0]       req_a1,
  input  logic [N*d-1:0]       req_b0,
  input  logic [N*d-1:0]       req_b1,
  input  logic [d*(d-1)-1:0]   rnd_in,
  input  logic                 rnd_valid,
  output logic                 rnd_ready,
  output logic [d-1:0]         out0,
  output logic [d-1:0]         out1,
  output logic [N-1:0]         out_valid
);

  localparam int PW = $clog2(N);
  localparam int NR = d * (d - 1);

  logic [N-1:0]  grant_q;
  logic [N-1:0]  tag_q;
  logic [PW-1:0] ptr;

  logic          issue;
  logic [N-1:0]  cand;
  logic          found;
  logic [PW-1:0] winner;
  logic [PW-1:0] ptr_nxt;
  logic [N-1:0]  grant_nxt;
  int            scan_idx;

  logic [d-1:0]  g_a0, g_a1, g_b0, g_b1;
  logic [NR-1:0] g_rnd;

  // Handshakes: a transfer happens on a cycle where valid and ready are both 1;
  // requesters hold valid and operands stable until ready, and ready may depend
  // on valid only through the granted slot (req_ready) or not at all (rnd_ready).
  assign issue     = (|grant_q) & rnd_valid;
  assign req_ready = grant_q & {N{rnd_valid}};
  assign rnd_ready = |grant_q;
  assign out_valid = tag_q;

  // The issuing requester is removed from the scan so its freshly accepted
  // request cannot be granted twice.
  assign cand = req_valid & ~(issue ? grant_q : '0);

  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = 0;
    for (int k = 0; k < N; k++) begin
      scan_idx = int'(ptr) + k;
      if (scan_idx >= N)
        scan_idx = scan_idx - N;
      if (!found && cand[scan_idx]) begin
        found  = 1'b1;
        winner = PW'(scan_idx);
      end
    end
  end

  assign grant_nxt = found ? (N'(1) << winner) : '0;
  assign ptr_nxt   = (winner == PW'(N - 1)) ? '0 : winner + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q <= '0;
      ptr     <= '0;
      tag_q   <= '0;
    end else begin
      if (grant_q == '0 || issue) begin
        grant_q <= grant_nxt;
        if (found)
          ptr <= ptr_nxt;
      end
      tag_q <= issue ? grant_q : '0;
    end
  end

  // Operand selection depends only on registered grant_q, so gadget inputs
  // are stable for the whole issue cycle.
  always_comb begin
    g_a0 = '0;
    g_a1 = '0;
    g_b0 = '0;
    g_b1 = '0;
    for (int i = 0; i < N; i++) begin
      g_a0 = g_a0 | (req_a0[i*d +: d] & {d{grant_q[i]}});
      g_a1 = g_a1 | (req_a1[i*d +: d] & {d{grant_q[i]}});
      g_b0 = g_b0 | (req_b0[i*d +: d] & {d{grant_q[i]}});
      g_b1 = g_b1 | (req_b1[i*d +: d] & {d{grant_q[i]}});
    end
  end

  assign g_rnd = issue ? rnd_in : '0;

  msk_g4mul_dom #(.d(d)) u_gadget (
    .clk  (clk),
    .a0   (g_a0),
    .a1   (g_a1),
    .b0   (g_b0),
    .b1   (g_b1),
    .rnd  (g_rnd),
    .out0 (out0),
    .out1 (out1)
  );

endmodule

// File: tb/tb_msk_g4mul_arbiter.sv
// Bench for msk_g4mul_arbiter: directed vector table, multi-cycle corner
// sequences and a random stress phase, all checked against a result queue.

module tb_msk_g4mul_arbiter;

  localparam int D  = 2;
  localparam int N  = 4;
  localparam int NR = D * (D - 1);
  localparam int W  = N + 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*D-1:0]  req_a0 = '0;
  logic [N*D-1:0]  req_a1 = '0;
  logic [N*D-1:0]  req_b0 = '0;
  logic [N*D-1:0]  req_b1 = '0;
  logic [NR-1:0]   rnd_in = '0;
  logic            rnd_valid = 1'b0;
  logic            rnd_ready;
  logic [D-1:0]    out0;
  logic [D-1:0]    out1;
  logic [N-1:0]    out_valid;

  int              n_checks = 0;
  int              n_fail = 0;
  logic [W-1:0]    exp_q[$];

  msk_g4mul_arbiter #(.d(D), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a0    (req_a0),
    .req_a1    (req_a1),
    .req_b0    (req_b0),
    .req_b1    (req_b1),
    .rnd_in    (rnd_in),
    .rnd_valid (rnd_valid),
    .rnd_ready (rnd_ready),
    .out0      (out0),
    .out1      (out1),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Shift-and-add reference multiply, reduced by x^2 + x + 1.
  function automatic logic [1:0] ref_mul(input logic [1:0] x, input logic [1:0] y);
    logic [2:0] acc;
    acc = '0;
    if (y[0]) acc = acc ^ {1'b0, x};
    if (y[1]) acc = acc ^ {x, 1'b0};
    if (acc[2]) acc = acc ^ 3'b111;
    return acc[1:0];
  endfunction

  function automatic logic [1:0] recombine(input logic [D-1:0] v0, input logic [D-1:0] v1);
    return {^v1, ^v0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic new_op(input int i);
    req_a0[i*D +: D] = D'($urandom_range(0, (1 << D) - 1));
    req_a1[i*D +: D] = D'($urandom_range(0, (1 << D) - 1));
    req_b0[i*D +: D] = D'($urandom_range(0, (1 << D) - 1));
    req_b1[i*D +: D] = D'($urandom_range(0, (1 << D) - 1));
  endtask

  // Scoreboard: an accepted request must come back exactly one cycle later.
  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    int           idx;
    logic [1:0]   a, b;
    if (rst) begin
      exp_q.delete();
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst req_ready", 32'(req_ready), 32'd0);
      check("rst rnd_ready", 32'(rnd_ready), 32'd0);
    end else begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb out_valid", 32'(out_valid), 32'(e[W-1:2]));
        check("sb product", 32'(recombine(out0, out1)), 32'(e[1:0]));
      end else begin
        check("sb idle out_valid", 32'(out_valid), 32'd0);
      end
      check("ready onehot0", 32'($onehot0(req_ready)), 32'd1);
      check("ready within valid", 32'(req_ready & ~req_valid), 32'd0);
      check("rnd consumed iff issue", 32'(rnd_valid & rnd_ready), 32'(|req_ready));
      if ((req_ready & req_valid) != '0) begin
        idx = 0;
        for (int i = 0; i < N; i++)
          if (req_ready[i]) idx = i;
        a = recombine(req_a0[idx*D +: D], req_a1[idx*D +: D]);
        b = recombine(req_b0[idx*D +: D], req_b1[idx*D +: D]);
        exp_q.push_back({req_ready, ref_mul(a, b)});
      end
    end
  end

  typedef struct {
    int         req;
    logic [1:0] as1, as0, bs1, bs0;
    logic [1:0] rnd;
    logic [1:0] exp;
  } vec_t;

  vec_t         vecs[6];
  logic [N-1:0] acc;
  logic [N-1:0] oh;
  int           wait_cnt[N];
  bit           got;

  initial begin
    // element shares: share1 / share0 of a and b, random bits, expected product
    vecs[0] = '{req: 2, as1: 2'b01, as0: 2'b11, bs1: 2'b10, bs0: 2'b00, rnd: 2'b00, exp: 2'b11};
    vecs[1] = '{req: 0, as1: 2'b11, as0: 2'b00, bs1: 2'b01, bs0: 2'b10, rnd: 2'b10, exp: 2'b10};
    vecs[2] = '{req: 1, as1: 2'b10, as0: 2'b11, bs1: 2'b11, bs0: 2'b01, rnd: 2'b01, exp: 2'b10};
    vecs[3] = '{req: 3, as1: 2'b00, as0: 2'b10, bs1: 2'b01, bs0: 2'b10, rnd: 2'b11, exp: 2'b01};
    vecs[4] = '{req: 0, as1: 2'b00, as0: 2'b00, bs1: 2'b11, bs0: 2'b00, rnd: 2'b11, exp: 2'b00};
    vecs[5] = '{req: 1, as1: 2'b01, as0: 2'b10, bs1: 2'b11, bs0: 2'b11, rnd: 2'b10, exp: 2'b00};

    // clock / reset
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post-reset out_valid", 32'(out_valid), 32'd0);
    check("post-reset req_ready", 32'(req_ready), 32'd0);
    check("post-reset rnd_ready", 32'(rnd_ready), 32'd0);
    step();

    // table: single requester from idle
    foreach (vecs[v]) begin
      oh = N'(1) << vecs[v].req;
      req_a0[vecs[v].req*D +: D] = {vecs[v].as1[0], vecs[v].as0[0]};
      req_a1[vecs[v].req*D +: D] = {vecs[v].as1[1], vecs[v].as0[1]};
      req_b0[vecs[v].req*D +: D] = {vecs[v].bs1[0], vecs[v].bs0[0]};
      req_b1[vecs[v].req*D +: D] = {vecs[v].bs1[1], vecs[v].bs0[1]};
      rnd_in = vecs[v].rnd;
      rnd_valid = 1'b1;
      req_valid = oh;
      @(negedge clk);
      check("vec ready before grant", 32'(req_ready), 32'd0);
      step();
      @(negedge clk);
      check("vec req_ready", 32'(req_ready), 32'(oh));
      check("vec rnd_ready", 32'(rnd_ready), 32'd1);
      step();
      req_valid = '0;
      @(negedge clk);
      check("vec out_valid", 32'(out_valid), 32'(oh));
      check("vec product", 32'(recombine(out0, out1)), 32'(vecs[v].exp));
      step();
    end

    // all four valid out of reset: issue order 0,1,2,3 back to back
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < N; i++) new_op(i);
    req_valid = '1;
    rnd_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rr req_ready", 32'(req_ready), (k >= 1 && k <= 4) ? (32'd1 << (k - 1)) : 32'd0);
      check("rr out_valid", 32'(out_valid), (k >= 2 && k <= 5) ? (32'd1 << (k - 2)) : 32'd0);
      acc = req_ready & req_valid;
      step();
      req_valid = req_valid & ~acc;
      rnd_in = NR'($urandom_range(0, (1 << NR) - 1));
    end
    new_op(0);
    req_valid = 4'b0001;
    @(negedge clk);
    check("rr again idle", 32'(req_ready), 32'd0);
    step();
    @(negedge clk);
    check("rr again req0", 32'(req_ready), 32'b0001);
    step();
    req_valid = '0;
    @(negedge clk);
    check("rr again out", 32'(out_valid), 32'b0001);
    step();

    // randomness stall while requester 1 is granted
    new_op(1);
    rnd_valid = 1'b0;
    req_valid = 4'b0010;
    @(negedge clk);
    check("stall pre rnd_ready", 32'(rnd_ready), 32'd0);
    step();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall rnd_ready", 32'(rnd_ready), 32'd1);
      check("stall req_ready", 32'(req_ready), 32'd0);
      check("stall out_valid", 32'(out_valid), 32'd0);
      step();
    end
    rnd_valid = 1'b1;
    @(negedge clk);
    check("stall release ready", 32'(req_ready), 32'b0010);
    step();
    req_valid = '0;
    @(negedge clk);
    check("stall result", 32'(out_valid), 32'b0010);
    step();

    // lone requester 3 kept valid: accepts only every second cycle
    new_op(3);
    req_valid = 4'b1000;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("lone ready", 32'(req_ready), (k % 2 == 1) ? 32'b1000 : 32'd0);
      acc = req_ready & req_valid;
      step();
      if (acc[3]) new_op(3);
    end
    req_valid = '0;
    step();
    step();

    // reset right after an issue
    new_op(2);
    new_op(3);
    req_valid = 4'b1100;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (req_ready != '0) got = 1'b1;
      step();
    end
    check("mid-reset issue seen", 32'(got), 32'd1);
    rst = 1'b1;
    for (int i = 0; i < N; i++) new_op(i);
    req_valid = 4'b1110;
    @(negedge clk);
    check("mid-reset out_valid", 32'(out_valid), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("after reset out_valid", 32'(out_valid), 32'd0);
    check("after reset ready", 32'(req_ready), 32'd0);
    step();
    @(negedge clk);
    check("after reset lowest first", 32'(req_ready), 32'b0010);
    step();
    req_valid = 4'b1100;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      acc = req_ready & req_valid;
      step();
      req_valid = req_valid & ~acc;
    end
    check("after reset drained", 32'(req_valid), 32'd0);

    // random stress
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      rnd_in = NR'($urandom_range(0, (1 << NR) - 1));
      rnd_valid = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      acc = req_ready & req_valid;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          check("wait within N issues", 32'(wait_cnt[i] <= N), 32'd1);
          wait_cnt[i] = 0;
        end else if (req_valid[i] && acc != '0) begin
          wait_cnt[i]++;
        end
      end
      step();
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          if ($urandom_range(0, 1) == 1) new_op(i);
          else req_valid[i] = 1'b0;
        end else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          new_op(i);
          req_valid[i] = 1'b1;
        end
      end
    end

    // drain what is still pending
    rnd_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      acc = req_ready & req_valid;
      step();
      req_valid = req_valid & ~acc;
    end
    check("stress drained", 32'(req_valid), 32'd0);
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
